// File: rtl/riscv_irq_ctrl.sv
// riscv_irq_ctrl: fixed-priority interrupt controller sitting between the
// peripherals and riscv_core.  It grants one masked request at a time and
// holds that grant until the core returns from the trap handler.
//
// Build option: define IRQ_EDGE_EN for edge-triggered sources, which are
// captured in a pending register.  Without it the sources are
// level-sensitive and are used directly as the pending vector.
//
// Core handshake: irq_req_o rises with irq_cause_o valid, and both stay
// stable until the core pulses irq_ret_i (its mret).  At that edge the
// grant drops, irq_ack_o pulses one-hot for one cycle to the serviced
// source, and there is at least one idle cycle before the next grant.
// irq_ret_i is ignored while no grant is outstanding.

module riscv_irq_ctrl #(
    parameter int          N_SRC      = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic [N_SRC-1:0] irq_mask_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] irq_ack_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_id;
    logic [3:0]         w_id_next;
    logic               r_req;
    logic               w_req_next;
    logic [31:0]        r_cause;
    logic [31:0]        w_cause_next;
    logic [N_SRC-1:0]   r_ack;
    logic [N_SRC-1:0]   w_ack_next;

    logic [N_SRC-1:0]   w_pending;
    logic [N_SRC-1:0]   w_req_vec;
    logic [N_SRC-1:0]   w_id_onehot;
    logic [3:0]         w_win_id;
    logic               w_ret_active;

    // The grant being retired this cycle; drives both the ack and the clear.
    assign w_ret_active = (r_state == ST_ACTIVE) && irq_ret_i;

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0]   r_src_q;
    logic [N_SRC-1:0]   r_pending;
    logic [N_SRC-1:0]   w_clear;
    logic [N_SRC-1:0]   w_set;

    assign w_set   = irq_src_i & ~r_src_q;
    assign w_clear = w_ret_active ? w_id_onehot : '0;

    // Capture rising edges; a fresh edge wins over the clear of the same bit
    // so an interrupt arriving during mret is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_src_q   <= '0;
            r_pending <= '0;
        end else begin
            r_src_q   <= irq_src_i;
            r_pending <= (r_pending & ~w_clear) | w_set;
        end
    end

    assign w_pending = r_pending;
`else
    // Level sources: the line itself is the pending state; the peripheral
    // drops it in response to irq_ack_o.
    assign w_pending = irq_src_i;
`endif

    assign w_req_vec = w_pending & irq_mask_i;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_win_id = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req_vec[i]) begin
                w_win_id = 4'(i);
            end
        end
    end

    // One-hot decode of the frozen grant id.
    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_id_onehot[i] = (r_id == 4'(i));
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        w_req_next   = 1'b0;
        w_cause_next = 32'd0;
        w_ack_next   = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req_vec) begin
                    w_state_next = ST_ACTIVE;
                    w_id_next    = w_win_id;
                    w_req_next   = 1'b1;
                    w_cause_next = CAUSE_BASE + {28'd0, w_win_id};
                end
            end
            ST_ACTIVE: begin
                if (irq_ret_i) begin
                    w_state_next = ST_IDLE;
                    w_ack_next   = w_id_onehot;
                end else begin
                    // Grant is frozen: no preemption, mask changes ignored.
                    w_req_next   = 1'b1;
                    w_cause_next = CAUSE_BASE + {28'd0, r_id};
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any grant without an ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_id    <= 4'd0;
            r_req   <= 1'b0;
            r_cause <= 32'd0;
            r_ack   <= '0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
            r_req   <= w_req_next;
            r_cause <= w_cause_next;
            r_ack   <= w_ack_next;
        end
    end

    assign irq_req_o   = r_req;
    assign irq_cause_o = r_cause;
    assign irq_ack_o   = r_ack;

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// Directed bench for riscv_irq_ctrl.  Works for both builds: with
// IRQ_EDGE_EN sources are pulsed for one cycle, otherwise they are held
// until their ack, and the request latency differs (2 vs 1 edges).
module tb_riscv_irq_ctrl;

`ifdef IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
  localparam int LAT  = 2;
`else
  localparam bit EDGE = 1'b0;
  localparam int LAT  = 1;
`endif

  // Value of irq_req_o one edge after a source first appears.
  localparam logic [31:0] EARLY_REQ = (LAT == 1) ? 32'd1 : 32'd0;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] irq_src_i;
  logic [15:0] irq_mask_i;
  logic        irq_ret_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;
  logic [15:0] irq_ack_o;

  int n_pass;
  int n_total;

  riscv_irq_ctrl #(
    .N_SRC      (16),
    .CAUSE_BASE (32'h8000_0010)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_src_i   (irq_src_i),
    .irq_mask_i  (irq_mask_i),
    .irq_ret_i   (irq_ret_i),
    .irq_req_o   (irq_req_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o)
  );

  // clock
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance one rising edge, then settle; inputs driven here land before
  // the next edge and outputs read here reflect the edge just taken.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Retire the current grant with a one-cycle mret pulse.
  task automatic ret_pulse();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_i      = 1'b1;
    irq_src_i  = 16'hFFFF;
    irq_mask_i = 16'hFFFF;
    irq_ret_i  = 1'b0;

    // Reset held 3 cycles with every source high: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", {31'd0, irq_req_o}, 32'd0);
      chk("rst_cause", irq_cause_o, 32'd0);
      chk("rst_ack", {16'd0, irq_ack_o}, 32'd0);
    end
    rst_i = 1'b0;
    tick();
    chk("rel_lat", {31'd0, irq_req_o}, EARLY_REQ);
    if (EDGE) tick();
    chk("rel_req", {31'd0, irq_req_o}, 32'd1);
    chk("rel_cause", irq_cause_o, 32'h8000_0010);

    // Reset while ACTIVE: grant dropped, no ack, nothing re-requested.
    irq_src_i = 16'h0000;
    rst_i = 1'b1;
    tick();
    chk("rstact_req", {31'd0, irq_req_o}, 32'd0);
    chk("rstact_ack", {16'd0, irq_ack_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    chk("rstact_ack2", {16'd0, irq_ack_o}, 32'd0);
    tick();
    tick();
    chk("rstact_noreq", {31'd0, irq_req_o}, 32'd0);

    // Single source 5.
    irq_src_i = 16'h0020;
    tick();
    chk("s5_lat", {31'd0, irq_req_o}, EARLY_REQ);
    if (EDGE) irq_src_i = 16'h0000;
    tick();
    chk("s5_req", {31'd0, irq_req_o}, 32'd1);
    chk("s5_cause", irq_cause_o, 32'h8000_0015);
    tick();
    chk("s5_hold", {31'd0, irq_req_o}, 32'd1);
    ret_pulse();
    chk("s5_ret_req", {31'd0, irq_req_o}, 32'd0);
    chk("s5_ret_cause", irq_cause_o, 32'd0);
    chk("s5_ack", {16'd0, irq_ack_o}, 32'h0000_0020);
    irq_src_i = 16'h0000;
    tick();
    chk("s5_ack_off", {16'd0, irq_ack_o}, 32'd0);
    chk("s5_idle", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("s5_noregrant", {31'd0, irq_req_o}, 32'd0);

    // Priority: 9 and 3 together, then 1 arrives during the grant of 3.
    irq_src_i = 16'h0208;
    tick();
    if (EDGE) irq_src_i = 16'h0000;
    if (!EDGE) irq_src_i = 16'h0208;
    repeat (LAT - 1) tick();
    chk("pri_req", {31'd0, irq_req_o}, 32'd1);
    chk("pri_cause3", irq_cause_o, 32'h8000_0013);
    irq_src_i = irq_src_i | 16'h0002;
    tick();
    if (EDGE) irq_src_i = 16'h0000;
    tick();
    tick();
    chk("pri_nopreempt", irq_cause_o, 32'h8000_0013);
    ret_pulse();
    chk("pri_ack3", {16'd0, irq_ack_o}, 32'h0000_0008);
    chk("pri_gap", {31'd0, irq_req_o}, 32'd0);
    irq_src_i = irq_src_i & ~16'h0008;
    tick();
    chk("pri_req1", {31'd0, irq_req_o}, 32'd1);
    chk("pri_cause1", irq_cause_o, 32'h8000_0011);
    ret_pulse();
    chk("pri_ack1", {16'd0, irq_ack_o}, 32'h0000_0002);
    irq_src_i = irq_src_i & ~16'h0002;
    tick();
    chk("pri_cause9", irq_cause_o, 32'h8000_0019);
    ret_pulse();
    chk("pri_ack9", {16'd0, irq_ack_o}, 32'h0000_0200);
    irq_src_i = 16'h0000;
    tick();
    chk("pri_done", {31'd0, irq_req_o}, 32'd0);

    // Masking: source 2 waits while masked, granted once enabled.
    irq_mask_i = 16'h0000;
    irq_src_i  = 16'h0004;
    tick();
    if (EDGE) irq_src_i = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mask_noreq", {31'd0, irq_req_o}, 32'd0);
    end
    irq_mask_i = 16'h0004;
    tick();
    chk("mask_req", {31'd0, irq_req_o}, 32'd1);
    chk("mask_cause", irq_cause_o, 32'h8000_0012);
    ret_pulse();
    chk("mask_ack", {16'd0, irq_ack_o}, 32'h0000_0004);
    irq_src_i  = 16'h0000;
    irq_mask_i = 16'hFFFF;
    tick();
    chk("mask_done", {31'd0, irq_req_o}, 32'd0);

    // Set/clear collision on source 4.
    irq_src_i = 16'h0010;
    tick();
    if (EDGE) irq_src_i = 16'h0000;
    repeat (LAT - 1) tick();
    chk("col_cause", irq_cause_o, 32'h8000_0014);
    irq_src_i = 16'h0010;
    ret_pulse();
    chk("col_ack", {16'd0, irq_ack_o}, 32'h0000_0010);
    chk("col_gap", {31'd0, irq_req_o}, 32'd0);
    if (EDGE) irq_src_i = 16'h0000;
    tick();
    chk("col_ack_off", {16'd0, irq_ack_o}, 32'd0);
    chk("col_rereq", {31'd0, irq_req_o}, 32'd1);
    chk("col_recause", irq_cause_o, 32'h8000_0014);
    ret_pulse();
    chk("col_ack2", {16'd0, irq_ack_o}, 32'h0000_0010);
    irq_src_i = 16'h0000;
    tick();
    chk("col_done", {31'd0, irq_req_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
